mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: DATA_WIDTH, 32, width of data word and MEM_result address.
REQ-002 Parameter: ADDR_WIDTH, 10, word-address width to data RAM.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 MEM_ramwe  in  1  store request from EX/MEM register.
REQ-006 MEM_rambyte  in  1  byte-size access when 1, word when 0.
REQ-007 MEM_ramtoreg  in  1  load request from EX/MEM register.
REQ-008 MEM_result  in  DATA_WIDTH  byte address of access.
REQ-009 MEM_r2  in  DATA_WIDTH  store data; byte stores use bits [7:0].
REQ-010 ram_req  out  1  RAM transaction request, held until ram_ack.
REQ-011 ram_we  out  1  1 = write transaction, 0 = read.
REQ-012 ram_addr  out  ADDR_WIDTH  word address = MEM_result[ADDR_WIDTH+1:2].
REQ-013 ram_wdata  out  DATA_WIDTH  write data.
REQ-014 ram_rdata  in  DATA_WIDTH  read data, valid in ack cycle of a read.
REQ-015 ram_ack  in  1  transaction complete; honoured only while ram_req=1.
REQ-016 mem_stall  out  1  1 = hold EX/MEM and earlier stages (drives their en low).
REQ-017 load_data  out  DATA_WIDTH  registered load result for MEM/WB.
REQ-018 load_valid  out  1  one-cycle pulse: load_data updated this cycle.

Function
REQ-019 FSM states: IDLE, RD, WR, RMW_RD, RMW_WR, DONE.
REQ-020 IDLE: MEM_ramwe&!MEM_rambyte -> WR; MEM_ramwe&MEM_rambyte -> RMW_RD; !MEM_ramwe&MEM_ramtoreg -> RD; else stay IDLE.
REQ-021 Store has priority when MEM_ramwe and MEM_ramtoreg both 1 (load ignored).
REQ-022 ram_req=1 in RD, WR, RMW_RD, RMW_WR; 0 in IDLE, DONE.
REQ-023 ram_we=1 in WR, RMW_WR only; ram_addr and ram_wdata stable while ram_req=1.
REQ-024 Transaction completes on cycle with ram_req=1 and ram_ack=1; ack latency 1..unbounded cycles; no timeout.
REQ-025 RD + ack: word load -> load_data=ram_rdata; byte load -> load_data={24'b0, lane byte}; next state DONE.
REQ-026 Byte lane little-endian: MEM_result[1:0]=0 selects [7:0], 3 selects [31:24].
REQ-027 WR: ram_wdata=MEM_r2; on ack -> DONE.
REQ-028 RMW_RD + ack: capture ram_rdata into merge register with selected lane replaced by MEM_r2[7:0] -> RMW_WR; ram_req stays 1, new transaction starts next cycle.
REQ-029 RMW_WR: ram_wdata=merge register; on ack -> DONE.
REQ-030 DONE: one cycle, unconditional -> IDLE; pipeline advances at its closing edge.
REQ-031 mem_stall=1 in RD, WR, RMW_RD, RMW_WR, and combinationally in IDLE when a request is present; 0 in DONE and idle-without-request.
REQ-032 Word accesses ignore MEM_result[1:0]; no misalignment trap.
REQ-033 load_valid pulses for the single cycle after RD ack (state DONE entered from RD); load_data otherwise holds last value.
REQ-034 Minimum latency: word load/store 3 cycles (IDLE, RD/WR with same-cycle-next ack, DONE); byte store 4 cycles.

Reset
REQ-035 rst=1 at any edge, including mid-transaction: state=IDLE, ram_req=0, ram_we=0, load_data=0, load_valid=0, merge register=0; mem_stall follows REQ-031 next cycle.
REQ-036 Aborted RAM transaction is dropped; ram_ack arriving after reset is ignored.

Verification
REQ-037 Word load, MEM_result=0x0000_0008, ram_ack 1 cycle after req, ram_rdata=0xDEAD_BEEF -> ram_addr=2, load_data=0xDEADBEEF, load_valid one pulse, mem_stall high 2 cycles.
REQ-038 Byte store, MEM_result=0x0000_0005, MEM_r2=0x0000_00AB, RAM word 0x1122_3344 -> read then write at ram_addr=1, ram_wdata=0x1122_AB44.
REQ-039 Byte load, MEM_result=0x0000_0013, ram_rdata=0x8877_6655 -> load_data=0x0000_0088.
REQ-040 Store+load both asserted, ack delayed 5 cycles -> only write issued, ram_we=1, mem_stall high 6 cycles, load_valid never pulses.
REQ-041 rst asserted in RMW_RD before ack -> next cycle ram_req=0, state IDLE, load_data=0; late ram_ack ignored.
REQ-042 Back-to-back word stores to addresses 0x0 and 0x4 with immediate ack -> two WR transactions separated by DONE/IDLE, no dropped or duplicated write.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage memory access sequencer: word/byte loads, word stores and
// byte stores done as read-modify-write against a req/ack data RAM.
module mem_access_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MEM_ramwe,
    input  logic                  MEM_rambyte,
    input  logic                  MEM_ramtoreg,
    input  logic [DATA_WIDTH-1:0] MEM_result,
    input  logic [DATA_WIDTH-1:0] MEM_r2,
    output logic                  ram_req,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    input  logic                  ram_ack,
    output logic                  mem_stall,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_valid
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        WR     = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t                state, next_state;
    logic [DATA_WIDTH-1:0] merge;
    logic [DATA_WIDTH-1:0] merged;
    logic [7:0]            lane_byte;
    logic [1:0]            lane;
    logic                  request;
    logic                  unused_addr_bits;

    // The EX/MEM register is frozen by mem_stall, so address and store data
    // can be taken straight from it for the whole transaction.
    assign lane     = MEM_result[1:0];
    assign ram_addr = MEM_result[ADDR_WIDTH+1:2];
    assign request  = MEM_ramwe | MEM_ramtoreg;
    assign unused_addr_bits = ^MEM_result[DATA_WIDTH-1:ADDR_WIDTH+2];

    assign lane_byte = ram_rdata[{lane, 3'b000} +: 8];

    always_comb begin
        merged = ram_rdata;
        merged[{lane, 3'b000} +: 8] = MEM_r2[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (MEM_ramwe)         next_state = MEM_rambyte ? RMW_RD : WR;
                else if (MEM_ramtoreg) next_state = RD;
            end
            RD:      if (ram_ack) next_state = DONE;
            WR:      if (ram_ack) next_state = DONE;
            RMW_RD:  if (ram_ack) next_state = RMW_WR;
            RMW_WR:  if (ram_ack) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ram_req   = 1'b0;
        ram_we    = 1'b0;
        ram_wdata = MEM_r2;
        mem_stall = 1'b0;
        case (state)
            IDLE:   mem_stall = request;
            RD: begin
                ram_req   = 1'b1;
                mem_stall = 1'b1;
            end
            WR: begin
                ram_req   = 1'b1;
                ram_we    = 1'b1;
                mem_stall = 1'b1;
            end
            RMW_RD: begin
                ram_req   = 1'b1;
                mem_stall = 1'b1;
            end
            RMW_WR: begin
                ram_req   = 1'b1;
                ram_we    = 1'b1;
                ram_wdata = merge;
                mem_stall = 1'b1;
            end
            default: ;
        endcase
    end

    // Load result and merge word; ack is only acted on in request states.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_data  <= '0;
            load_valid <= 1'b0;
            merge      <= '0;
        end else begin
            load_valid <= (state == RD) && ram_ack;
            if ((state == RD) && ram_ack)
                load_data <= MEM_rambyte ? {{(DATA_WIDTH-8){1'b0}}, lane_byte} : ram_rdata;
            if ((state == RMW_RD) && ram_ack)
                merge <= merged;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: RAM handshake driven cycle by cycle,
// outputs sampled on the falling edge.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_ramwe, MEM_rambyte, MEM_ramtoreg;
    logic [31:0] MEM_result, MEM_r2;
    logic        ram_req, ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic        ram_ack;
    logic        mem_stall;
    logic [31:0] load_data;
    logic        load_valid;

    int vectors = 0;
    int miscompares = 0;
    int writes = 0;
    logic [9:0] wr_addr_log [0:7];

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
        .clk(clk), .rst(rst),
        .MEM_ramwe(MEM_ramwe), .MEM_rambyte(MEM_rambyte), .MEM_ramtoreg(MEM_ramtoreg),
        .MEM_result(MEM_result), .MEM_r2(MEM_r2),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack),
        .mem_stall(mem_stall), .load_data(load_data), .load_valid(load_valid)
    );

    // Completed write handshakes, as the RAM would see them.
    always @(posedge clk) begin
        if (!rst && ram_req && ram_we && ram_ack) begin
            if (writes < 8) wr_addr_log[writes] = ram_addr;
            writes = writes + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        MEM_ramwe = 0; MEM_rambyte = 0; MEM_ramtoreg = 0;
        MEM_result = 0; MEM_r2 = 0;
    endtask

    int stall_cnt;
    int lv_seen;
    int wr_base;

    initial begin
        rst = 1; ram_ack = 0; ram_rdata = 0;
        clear_req();
        tick(); tick();
        @(negedge clk);
        chk("rst_req", ram_req, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_ldata", load_data, 0);
        chk("rst_lvalid", load_valid, 0);
        chk("rst_stall", mem_stall, 0);
        tick();
        rst = 0;

        // Word load at 0x8, ack in first RD cycle
        MEM_ramtoreg = 1; MEM_result = 32'h8;
        @(negedge clk);
        chk("wl_idle_stall", mem_stall, 1);
        chk("wl_idle_req", ram_req, 0);
        tick();
        @(negedge clk);
        chk("wl_rd_req", ram_req, 1);
        chk("wl_rd_we", ram_we, 0);
        chk("wl_rd_addr", ram_addr, 2);
        chk("wl_rd_stall", mem_stall, 1);
        ram_ack = 1; ram_rdata = 32'hDEAD_BEEF;
        tick();
        ram_ack = 0; ram_rdata = 32'h0;
        @(negedge clk);
        chk("wl_done_lvalid", load_valid, 1);
        chk("wl_done_ldata", load_data, 32'hDEAD_BEEF);
        chk("wl_done_stall", mem_stall, 0);
        chk("wl_done_req", ram_req, 0);
        tick();
        clear_req();
        @(negedge clk);
        chk("wl_after_lvalid", load_valid, 0);
        chk("wl_after_hold", load_data, 32'hDEAD_BEEF);
        chk("wl_after_stall", mem_stall, 0);

        // Byte store at 0x5: RMW over 0x11223344
        MEM_ramwe = 1; MEM_rambyte = 1; MEM_result = 32'h5; MEM_r2 = 32'hAB;
        @(negedge clk);
        chk("bs_idle_stall", mem_stall, 1);
        tick();
        @(negedge clk);
        chk("bs_rd_req", ram_req, 1);
        chk("bs_rd_we", ram_we, 0);
        chk("bs_rd_addr", ram_addr, 1);
        ram_ack = 1; ram_rdata = 32'h1122_3344;
        tick();
        ram_ack = 0; ram_rdata = 32'h0;
        @(negedge clk);
        chk("bs_wr_req", ram_req, 1);
        chk("bs_wr_we", ram_we, 1);
        chk("bs_wr_addr", ram_addr, 1);
        chk("bs_wr_data", ram_wdata, 32'h1122_AB44);
        chk("bs_wr_stall", mem_stall, 1);
        tick();
        @(negedge clk);
        chk("bs_wr_hold_req", ram_req, 1);
        chk("bs_wr_hold_data", ram_wdata, 32'h1122_AB44);
        ram_ack = 1;
        tick();
        ram_ack = 0;
        @(negedge clk);
        chk("bs_done_req", ram_req, 0);
        chk("bs_done_lvalid", load_valid, 0);
        chk("bs_done_ldata", load_data, 32'hDEAD_BEEF);
        tick();
        clear_req();

        // Byte load at 0x13, lane 3
        MEM_ramtoreg = 1; MEM_rambyte = 1; MEM_result = 32'h13;
        tick();
        @(negedge clk);
        chk("bl_rd_addr", ram_addr, 4);
        ram_ack = 1; ram_rdata = 32'h8877_6655;
        tick();
        ram_ack = 0; ram_rdata = 32'h0;
        @(negedge clk);
        chk("bl_ldata", load_data, 32'h0000_0088);
        chk("bl_lvalid", load_valid, 1);
        tick();
        clear_req();

        // Store+load together, ack in 5th WR cycle
        MEM_ramwe = 1; MEM_ramtoreg = 1; MEM_result = 32'h20; MEM_r2 = 32'hCAFE_F00D;
        stall_cnt = 0; lv_seen = 0;
        @(negedge clk);
        if (mem_stall) stall_cnt++;
        for (int i = 1; i <= 5; i++) begin
            tick();
            @(negedge clk);
            if (mem_stall) stall_cnt++;
            if (load_valid) lv_seen++;
            if (i == 1) begin
                chk("sl_we", ram_we, 1);
                chk("sl_wdata", ram_wdata, 32'hCAFE_F00D);
            end
            if (i == 5) begin
                chk("sl_req_before_ack", ram_req, 1);
                ram_ack = 1;
            end
        end
        tick();
        ram_ack = 0;
        @(negedge clk);
        if (load_valid) lv_seen++;
        chk("sl_done_stall", mem_stall, 0);
        tick();
        clear_req();
        @(negedge clk);
        if (load_valid) lv_seen++;
        chk("sl_stall_cycles", stall_cnt, 6);
        chk("sl_no_lvalid", lv_seen, 0);

        // Reset mid RMW_RD, then a late ack
        MEM_ramwe = 1; MEM_rambyte = 1; MEM_result = 32'h5; MEM_r2 = 32'h55;
        tick();
        @(negedge clk);
        chk("rr_rmw_req", ram_req, 1);
        rst = 1;
        tick();
        @(negedge clk);
        chk("rr_req", ram_req, 0);
        chk("rr_we", ram_we, 0);
        chk("rr_ldata", load_data, 0);
        chk("rr_lvalid", load_valid, 0);
        rst = 0;
        clear_req();
        ram_ack = 1; ram_rdata = 32'hFFFF_FFFF;
        tick();
        @(negedge clk);
        chk("rr_late_req", ram_req, 0);
        chk("rr_late_stall", mem_stall, 0);
        ram_ack = 0; ram_rdata = 0;
        tick();
        @(negedge clk);
        chk("rr_idle_req", ram_req, 0);
        chk("rr_idle_lvalid", load_valid, 0);
        chk("rr_idle_ldata", load_data, 0);

        // Back-to-back word stores to 0x0 and 0x4, immediate ack
        tick();
        wr_base = writes;
        MEM_ramwe = 1; MEM_result = 32'h0; MEM_r2 = 32'h1111_1111;
        tick();
        @(negedge clk);
        chk("bb1_addr", ram_addr, 0);
        chk("bb1_wdata", ram_wdata, 32'h1111_1111);
        ram_ack = 1;
        tick();
        ram_ack = 0;
        MEM_result = 32'h4; MEM_r2 = 32'h2222_2222;
        @(negedge clk);
        chk("bb_done_req", ram_req, 0);
        tick();
        @(negedge clk);
        chk("bb_idle_stall", mem_stall, 1);
        chk("bb_idle_req", ram_req, 0);
        tick();
        @(negedge clk);
        chk("bb2_addr", ram_addr, 1);
        chk("bb2_wdata", ram_wdata, 32'h2222_2222);
        ram_ack = 1;
        tick();
        ram_ack = 0;
        clear_req();
        tick();
        @(negedge clk);
        chk("bb_write_count", writes - wr_base, 2);
        chk("bb_first_addr", wr_addr_log[wr_base], 0);
        chk("bb_second_addr", wr_addr_log[wr_base+1], 1);
        chk("bb_end_req", ram_req, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
